piarb_asa_queue_arb: RTL and testbench
======================================

PIARB_ASA_QUEUE_ARB -- requirements
Module: piarb_asa_queue_arb

Interface
REQ-001 SHALL have parameter DEPTH_BITS, default 4; the storage depth is 2**DEPTH_BITS.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports req0 and req1, input, 1 bit each: write requests from source 0 and source 1.
REQ-005 SHALL have ports din0 and din1, input, piarb_asa_meta_type: write data, sampled when the matching grant is high.
REQ-006 SHALL have ports gnt0 and gnt1, output, 1 bit each: combinational grants; the data is accepted in the same cycle.
REQ-007 SHALL have port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-008 SHALL have port out_data, output, piarb_asa_meta_type: the head entry.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts; the pop occurs when out_valid and out_ready are both high.
REQ-010 SHALL have port count, output, DEPTH_BITS+1 bits: the number of entries held in storage, excluding the output buffer.
REQ-011 SHALL have ports full and empty, output, 1 bit each: full = (count == DEPTH); empty = (count == 0) and no entry is buffered or in flight.

Function
REQ-012 SHALL grant at most one source per cycle, and only when full is low.
REQ-013 SHALL resolve a request from only one source by granting that source.
REQ-014 SHALL resolve simultaneous requests by round-robin: the rr pointer selects the winner, then toggles to the other source after any grant.
REQ-015 SHALL, on a grant, write the granted din to storage at wr_ptr and increment wr_ptr modulo DEPTH.
REQ-016 SHALL issue a storage read (rd_en) at rd_ptr when count != 0 and space > 0, where space = 2 - buf_cnt - rd_pend + pop.
REQ-017 SHALL increment rd_ptr modulo DEPTH on each rd_en.
REQ-018 SHALL update count each cycle by +grant and -rd_en; a grant and an rd_en in the same cycle leave count unchanged.
REQ-019 SHALL use storage with 1-cycle registered read latency; rd_pend is set the cycle after rd_en, and the data is captured into the output buffer at the end of that cycle.
REQ-020 SHALL implement the output buffer as a 2-entry skid buffer with states EMPTY, ONE and TWO.
REQ-021 SHALL move the output buffer EMPTY->ONE on capture.
REQ-022 SHALL move the output buffer ONE->TWO on capture without pop.
REQ-023 SHALL hold ONE on capture with pop.
REQ-024 SHALL move ONE->EMPTY on pop without capture.
REQ-025 SHALL move TWO->ONE on pop; capture in TWO is impossible by construction.
REQ-026 SHALL keep out_valid high in states ONE and TWO, with out_data as the oldest entry.
REQ-027 SHALL deliver entries strictly in grant order.
REQ-028 SHALL assert out_valid for a write granted in cycle N into an otherwise empty block in cycle N+3.
REQ-029 SHALL sustain one write and one pop per cycle indefinitely.
REQ-030 SHALL never read an address written in the same cycle; the rd_en gating on registered count guarantees this.
REQ-031 SHALL, while full, drop both grants, leave requests pending and keep the rr pointer unchanged.
REQ-032 SHALL, at DEPTH 16, wrap pointers 15->0 with no discontinuity in data order.
REQ-033 SHALL hold out_valid and out_data stable while out_ready is low.

Reset
REQ-034 SHALL, while rst is high, hold gnt0 and gnt1 at 0 and ignore requests.
REQ-035 SHALL, on reset, set count=0, wr_ptr=0, rd_ptr=0, rd_pend=0, buffer state EMPTY, out_valid=0, full=0, empty=1 and rr pointer to source 0.
REQ-036 SHALL, on reset mid-operation, discard all stored, in-flight and buffered entries; storage contents are not cleared and are never observed.
REQ-037 SHALL leave out_data don't-care while out_valid is 0.

Structure
REQ-038 SHALL take piarb_asa_meta_type from meta_package.
REQ-039 SHALL place the default DEPTH_BITS constant in meta_package as PIARB_ASA_Q_DEPTH_BITS.
REQ-040 SHALL instantiate exactly one sub-module: the existing 1R1W registered piarb_asa register-file macro, parameterized with DEPTH_BITS, with wr=grant and raddr=rd_ptr.
REQ-041 SHALL keep the arbiter, pointers, count and skid buffer in this module, at 150-300 lines.

Verification
REQ-042 SHALL cover single-source latency: req0 for one cycle (N) with din tag 0xA1, out_ready=1 -> gnt0 in N, out_valid in N+3 with tag 0xA1, empty=1 afterwards.
REQ-043 SHALL cover alternation: req0 and req1 held 8 cycles with tags 0x0n and 0x1n -> grants alternate 0,1,0,1 starting with 0 after reset; output order 0x00,0x10,0x01,0x11,...
REQ-044 SHALL cover fill and backpressure: out_ready=0, req0 held 25 cycles -> count reaches 16, full=1, with 18 grants total (16 stored + 2 buffered); gnt0=0 thereafter; release out_ready -> 18 entries in order, no loss or duplication.
REQ-045 SHALL cover wrap with 1/cycle throughput: 40 writes, out_ready=1 -> pointers wrap twice, out_valid high for 40 consecutive cycles after first output, data in order.
REQ-046 SHALL cover random backpressure: out_ready toggled every cycle with 30 writes -> scoreboard matches, out_data stable while out_ready=0.
REQ-047 SHALL cover mid-operation reset: 5 entries queued, rst pulsed 1 cycle -> next cycle out_valid=0, count=0, empty=1; new write 0x55 emerges first after 3 cycles.

Source files
------------

// File: rtl/piarb_asa_queue_arb_pkg.sv
// meta_package: types and constants shared by the two-source arbitrated queue.
//   PIARB_ASA_Q_DEPTH_BITS : default log2 of the storage depth
//   piarb_asa_meta_type    : one queue entry (tag + info byte)
//   skid_state_t           : occupancy states of the 2-entry output skid buffer
//   skid_fill()            : entries held by the skid buffer in a given state
package meta_package;

  localparam int PIARB_ASA_Q_DEPTH_BITS = 4;

  typedef struct packed {
    logic [7:0] tag;
    logic [7:0] info;
  } piarb_asa_meta_type;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } skid_state_t;

  function automatic logic [1:0] skid_fill(input skid_state_t s);
    case (s)
      BUF_ONE: return 2'd1;
      BUF_TWO: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/piarb_asa_queue_arb_rf.sv
// piarb_asa_queue_arb_rf: 1R1W register file with a registered read port.
//   clk        : clock
//   wr/waddr/wdata : write strobe, address and data (written at the rising edge)
//   rd/raddr   : read strobe and address
//   rdata      : read data, valid the cycle after rd
// Contents are never cleared; the queue logic never reads an unwritten slot.
module piarb_asa_queue_arb_rf
  import meta_package::*;
#(
  parameter int DEPTH_BITS = PIARB_ASA_Q_DEPTH_BITS
) (
  input  logic                  clk,
  input  logic                  wr,
  input  logic [DEPTH_BITS-1:0] waddr,
  input  piarb_asa_meta_type    wdata,
  input  logic                  rd,
  input  logic [DEPTH_BITS-1:0] raddr,
  output piarb_asa_meta_type    rdata
);

  piarb_asa_meta_type mem [2**DEPTH_BITS];

  always_ff @(posedge clk) begin
    if (wr) mem[waddr] <= wdata;
    if (rd) rdata <= mem[raddr];
  end

endmodule

// File: rtl/piarb_asa_queue_arb.sv
// piarb_asa_queue_arb: two-source round-robin arbiter feeding a circular queue
// with a 2-entry output skid buffer.
//   clk, rst            : clock, synchronous active-high reset
//   req0/req1, din0/din1: write requests and data from the two sources
//   gnt0/gnt1           : combinational grants; data accepted in the same cycle
//   out_valid/out_data  : head entry of the queue
//   out_ready           : consumer accept; pop = out_valid & out_ready
//   count               : entries in storage (excluding the output side)
//   full, empty         : storage full; nothing stored, in flight or buffered
module piarb_asa_queue_arb
  import meta_package::*;
#(
  parameter int DEPTH_BITS = PIARB_ASA_Q_DEPTH_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  piarb_asa_meta_type    din0,
  input  piarb_asa_meta_type    din1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  out_valid,
  output piarb_asa_meta_type    out_data,
  input  logic                  out_ready,
  output logic [DEPTH_BITS:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [DEPTH_BITS:0]   DEPTH_CNT = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [DEPTH_BITS:0]   CNT_ONE   = (DEPTH_BITS+1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE   = DEPTH_BITS'(1);

  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count_q;
  logic                  rr;
  logic                  rd_pend;
  logic                  grant;
  logic                  rd_en;
  logic                  pop;
  logic [2:0]            occupancy;
  logic [2:0]            limit;
  piarb_asa_meta_type    wdata;
  piarb_asa_meta_type    rf_rdata;
  piarb_asa_meta_type    buf0;
  piarb_asa_meta_type    buf1;
  skid_state_t           state;
  skid_state_t           state_next;
  logic                  load0_rf;
  logic                  load0_shift;
  logic                  load1_rf;

  // rr == 0 gives source 0 priority on a tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && !full) begin
      if (req0 && req1) begin
        if (rr) gnt1 = 1'b1;
        else    gnt0 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign grant = gnt0 | gnt1;
  assign wdata = gnt1 ? din1 : din0;

  assign out_valid = (state != BUF_EMPTY);
  assign out_data  = buf0;
  assign pop       = out_valid & out_ready;

  // A read may be issued only if the skid buffer can absorb it one cycle
  // later: buffered + in-flight - popped must stay below two. Gating on the
  // registered count means the slot being written this cycle is never read.
  assign occupancy = {1'b0, skid_fill(state)} + {2'b00, rd_pend};
  assign limit     = 3'd2 + {2'b00, pop};
  assign rd_en     = !rst && (count_q != '0) && (occupancy < limit);

  assign count = count_q;
  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0) && (state == BUF_EMPTY) && !rd_pend;

  piarb_asa_queue_arb_rf #(
    .DEPTH_BITS(DEPTH_BITS)
  ) u_rf (
    .clk  (clk),
    .wr   (grant),
    .waddr(wr_ptr),
    .wdata(wdata),
    .rd   (rd_en),
    .raddr(rd_ptr),
    .rdata(rf_rdata)
  );

  // Pointers, storage count, read-pending flag and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      rd_pend <= 1'b0;
      rr      <= 1'b0;
    end else begin
      rd_pend <= rd_en;
      if (grant) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        rr     <= gnt0;
      end
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({grant, rd_en})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Skid buffer state register.
  always_ff @(posedge clk) begin
    if (rst) state <= BUF_EMPTY;
    else     state <= state_next;
  end

  // Capture happens whenever a read is pending; the read gating keeps a
  // capture from ever arriving while the buffer is in TWO.
  always_comb begin
    state_next  = state;
    load0_rf    = 1'b0;
    load0_shift = 1'b0;
    load1_rf    = 1'b0;
    case (state)
      BUF_EMPTY: begin
        if (rd_pend) begin
          load0_rf   = 1'b1;
          state_next = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (rd_pend && pop) begin
          load0_rf = 1'b1;
        end else if (rd_pend) begin
          load1_rf   = 1'b1;
          state_next = BUF_TWO;
        end else if (pop) begin
          state_next = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (pop) begin
          load0_shift = 1'b1;
          state_next  = BUF_ONE;
        end
      end
      default: state_next = BUF_EMPTY;
    endcase
  end

  // Skid buffer data; contents are don't-care while the state says empty.
  always_ff @(posedge clk) begin
    if (load0_rf)         buf0 <= rf_rdata;
    else if (load0_shift) buf0 <= buf1;
    if (load1_rf)         buf1 <= rf_rdata;
  end

endmodule

// File: tb/tb_piarb_asa_queue_arb.sv
// tb_piarb_asa_queue_arb: directed bench for piarb_asa_queue_arb with a
// queue-based reference model checked every cycle plus literal expectations.
module tb_piarb_asa_queue_arb;
  import meta_package::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  logic req0, req1, out_ready;
  piarb_asa_meta_type din0, din1, out_data;
  logic gnt0, gnt1, out_valid, full, empty;
  logic [4:0] count;

  int n_vectors = 0;
  int n_miscompares = 0;

  logic [7:0] popped [$];

  piarb_asa_queue_arb #(
    .DEPTH_BITS(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .din0     (din0),
    .din1     (din1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then wait for the
  // falling edge where the outputs of that cycle are settled.
  task automatic applyStimulus(input logic r0, input logic r1, input logic [7:0] t0,
                               input logic [7:0] t1, input logic rdy);
    @(posedge clk);
    #1;
    req0      = r0;
    req1      = r1;
    din0      = '{tag: t0, info: ~t0};
    din1      = '{tag: t1, info: ~t1};
    out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference model: entries move store_q -> pend_q -> out_q as whole items.
  piarb_asa_meta_type store_q [$];
  piarb_asa_meta_type pend_q [$];
  piarb_asa_meta_type out_q [$];
  bit m_rr = 1'b0;

  initial begin
    logic e0, e1, do_pop, do_rd, prev_hold, prev_rst;
    piarb_asa_meta_type prev_data;
    prev_hold = 1'b0;
    prev_rst  = 1'b1;
    prev_data = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e0 = 1'b0;
      e1 = 1'b0;
      if (!rst && store_q.size() < DEPTH) begin
        if (req0 && req1) begin
          e0 = !m_rr;
          e1 = m_rr;
        end else begin
          e0 = req0;
          e1 = req1 && !req0;
        end
      end
      checkOutput("gnt0", 32'(gnt0), 32'(e0));
      checkOutput("gnt1", 32'(gnt1), 32'(e1));
      checkOutput("count", 32'(count), 32'(store_q.size()));
      checkOutput("full", 32'(full), 32'(store_q.size() == DEPTH));
      checkOutput("empty", 32'(empty),
                  32'(store_q.size() == 0 && pend_q.size() == 0 && out_q.size() == 0));
      checkOutput("out_valid", 32'(out_valid), 32'(out_q.size() > 0));
      if (out_q.size() > 0) checkOutput("out_data", 32'(out_data), 32'(out_q[0]));
      if (prev_hold && !prev_rst) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_data", 32'(out_data), 32'(prev_data));
      end
      prev_hold = out_valid && !out_ready;
      prev_rst  = rst;
      prev_data = out_data;
      if (!rst && out_valid && out_ready) popped.push_back(out_data.tag);

      if (rst) begin
        store_q.delete();
        pend_q.delete();
        out_q.delete();
        m_rr = 1'b0;
      end else begin
        do_pop = (out_q.size() > 0) && out_ready;
        do_rd  = (store_q.size() > 0) &&
                 ((out_q.size() + pend_q.size() - int'(do_pop)) < 2);
        if (do_pop) void'(out_q.pop_front());
        if (pend_q.size() > 0) out_q.push_back(pend_q.pop_front());
        if (do_rd) pend_q.push_back(store_q.pop_front());
        if (e0 || e1) begin
          store_q.push_back(e1 ? din1 : din0);
          m_rr = e0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int grants, cyc, run, max_run;
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    out_ready = 1'b0;
    din0 = '0;
    din1 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);

    $display("[TB] single-source latency");
    applyStimulus(1'b1, 1'b0, 8'hA1, 8'h00, 1'b1);
    checkOutput("t1_gnt0", 32'(gnt0), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("t1_valid_n1", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("t1_valid_n2", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("t1_valid_n3", 32'(out_valid), 32'd1);
    checkOutput("t1_tag", 32'(out_data.tag), 32'hA1);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("t1_empty_after", 32'(empty), 32'd1);

    $display("[TB] alternation");
    pulseReset();
    popped.delete();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b1, {4'h0, 4'(k / 2)}, {4'h1, 4'(k / 2)}, 1'b1);
      checkOutput("t2_gnt0", 32'(gnt0), 32'(k % 2 == 0));
      checkOutput("t2_gnt1", 32'(gnt1), 32'(k % 2 == 1));
    end
    repeat (8) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("t2_npop", 32'(popped.size()), 32'd8);
    for (int k = 0; k < 8 && k < popped.size(); k++)
      checkOutput("t2_order", 32'(popped[k]), 32'({4'(k % 2), 4'(k / 2)}));

    $display("[TB] fill and backpressure");
    grants = 0;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'h20 + i), 8'h00, 1'b0);
      if (gnt0) grants++;
    end
    checkOutput("t3_gnt0_full", 32'(gnt0), 32'd0);
    checkOutput("t3_count", 32'(count), 32'd16);
    checkOutput("t3_full", 32'(full), 32'd1);
    checkOutput("t3_grants", 32'(grants), 32'd18);
    popped.delete();
    repeat (25) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("t3_npop", 32'(popped.size()), 32'd18);
    for (int j = 0; j < 18 && j < popped.size(); j++)
      checkOutput("t3_order", 32'(popped[j]), 32'(8'h20 + j));

    $display("[TB] wrap at full throughput");
    popped.delete();
    run = 0;
    max_run = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, i < 40, 8'h00, 8'(8'h40 + i), 1'b1);
      if (i < 40) checkOutput("t4_gnt1", 32'(gnt1), 32'd1);
      run = out_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    checkOutput("t4_run", 32'(max_run), 32'd40);
    checkOutput("t4_npop", 32'(popped.size()), 32'd40);
    for (int j = 0; j < 40 && j < popped.size(); j++)
      checkOutput("t4_order", 32'(popped[j]), 32'(8'h40 + j));

    $display("[TB] toggling backpressure");
    popped.delete();
    grants = 0;
    cyc = 0;
    while (grants < 30 && cyc < 200) begin
      applyStimulus(1'b1, cyc % 3 == 0, 8'(cyc), 8'(cyc) | 8'h80, cyc % 2 == 1);
      if (gnt0 || gnt1) grants++;
      cyc++;
    end
    checkOutput("t5_writes", 32'(grants), 32'd30);
    for (int i = 0; i < 80; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, i % 2 == 1);
    checkOutput("t5_npop", 32'(popped.size()), 32'd30);
    checkOutput("t5_empty", 32'(empty), 32'd1);

    $display("[TB] mid-operation reset");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(8'h90 + i), 8'h00, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req0 = 1'b1;
    din0 = '{tag: 8'h99, info: 8'h66};
    @(negedge clk);
    checkOutput("t6_gnt_in_rst", 32'(gnt0), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req0 = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("t6_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_count", 32'(count), 32'd0);
    checkOutput("t6_empty", 32'(empty), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h55, 8'h00, 1'b1);
    checkOutput("t6_gnt0", 32'(gnt0), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("t6_valid_n2", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("t6_valid_n3", 32'(out_valid), 32'd1);
    checkOutput("t6_tag", 32'(out_data.tag), 32'h55);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
